// File: rtl/spi_target_if.sv
// SPI target endpoint: oversamples SCLK/EN/MOSI on clk, receives one word per frame
// and shifts a preloaded reply (or FILL_WORD) out on MISO, MSB first.
module spi_target_if #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL_WORD   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_CLK,
    input  logic              SPI_EN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, en_sync, mosi_sync;
    logic                   sclk_prev, en_prev;
    logic                   sclk_s, en_s, mosi_s;
    logic                   sclk_rise, sclk_fall, en_rise, en_fall;

    state_t             state_q;
    logic [DATA_W-1:0]  tx_shift_q, rx_shift_q, hold_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hold_full_q, hold_full_d, hold_load, hold_take;
    logic               rx_pend_q;

    // EN chain resets high so a frame already in progress at reset release is
    // not mistaken for a new frame start; EN must be seen low first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            en_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            en_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], SPI_EN};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_prev <= sclk_s;
            en_prev   <= en_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign en_s      = en_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign en_rise   = en_s & ~en_prev;
    assign en_fall   = ~en_s & en_prev;

    // Load and take never coincide: a load needs the register empty, a take needs it full.
    always_comb begin
        hold_load   = tx_valid & tx_ready;
        hold_take   = (state_q == StIdle) & en_rise & hold_full_q;
        hold_full_d = (hold_full_q & ~hold_take) | hold_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            rx_pend_q   <= 1'b0;
            tx_ready    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            rx_pend_q   <= 1'b0;
            hold_full_q <= hold_full_d;
            tx_ready    <= ~hold_full_d;
            if (hold_load) begin
                hold_q <= tx_data;
            end
            if (rx_pend_q) begin
                rx_data  <= rx_shift_q;
                rx_valid <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (en_rise) begin
                        state_q    <= StActive;
                        cnt_q      <= '0;
                        rx_shift_q <= '0;
                        if (hold_full_q) begin
                            tx_shift_q <= hold_q;
                        end else begin
                            tx_shift_q  <= FILL_WORD;
                            tx_underrun <= 1'b1;
                        end
                    end
                end
                StActive: begin
                    if (en_fall) begin
                        state_q   <= StIdle;
                        frame_err <= 1'b1;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                            cnt_q      <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                                state_q   <= StDone;
                                rx_pend_q <= 1'b1;
                            end
                        end
                        if (sclk_fall && (cnt_q < CNT_W'(DATA_W))) begin
                            tx_shift_q <= tx_shift_q << 1;
                        end
                    end
                end
                StDone: begin
                    if (en_fall) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign SPI_MISO = (state_q != StIdle) & tx_shift_q[DATA_W-1];
    assign busy     = (state_q != StIdle);

endmodule
